// File: rtl/mem_map_pkg.sv
// Address map and STATUS layout shared by the memory controller and its FIFO.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
package mem_map_pkg;

  localparam logic [31:0] MMIO_BASE   = 32'h4000_0000;
  localparam logic [31:0] TXDATA_ADDR = MMIO_BASE;
  localparam logic [31:0] STATUS_ADDR = MMIO_BASE + 32'd1;
  localparam logic [31:0] CYCLES_ADDR = MMIO_BASE + 32'd2;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_BAD   = 3;

  // Result of decoding one word address.
  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_TXDATA,
    SEL_STATUS,
    SEL_CYCLES,
    SEL_BAD
  } sel_e;

  function automatic logic [31:0] pack_status(input logic empty, input logic full,
                                              input logic ovf, input logic bad);
    logic [31:0] s;
    s           = '0;
    s[ST_EMPTY] = empty;
    s[ST_FULL]  = full;
    s[ST_OVF]   = ovf;
    s[ST_BAD]   = bad;
    return s;
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Core memory port plus TX byte stream, bundled for the memory controller.
// Latency: n/a (wiring only).
// Backpressure: TX side is valid/ready; the memory port has none (fixed latency).
// Ports: mem_addr/mem_wdata/mem_rd/mem_wr from the core, mem_rdata back to it;
//        tx_data/tx_valid to the byte consumer, tx_ready from it.
interface mem_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  mem_rd;
  logic                  mem_wr;
  logic [31:0]           mem_rdata;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  // Core and TX consumer side.
  modport master (
    output mem_addr, mem_wdata, mem_rd, mem_wr, tx_ready,
    input  mem_rdata, tx_data, tx_valid
  );

  // Memory controller side.
  modport slave (
    input  mem_addr, mem_wdata, mem_rd, mem_wr, tx_ready,
    output mem_rdata, tx_data, tx_valid
  );
endinterface

// File: rtl/mem_ctrl_tx_fifo.sv
// Small register-based byte FIFO feeding the console TX stream.
// Latency: a push is visible at head/empty right after its edge.
// Backpressure: push while full is refused unless a pop happens on the same edge.
// Ports: clk, reset (async active-low), push/push_data in, pop in,
//        full/empty flags and head entry out.
module tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int IW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full (wrap bits differ) from empty.
  logic [IW:0]      wr_ptr;
  logic [IW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[IW] != rd_ptr[IW]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
  assign pop_ok  = pop && !empty;
  // A simultaneous pop frees the slot this push needs when full.
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr[IW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      // Storage is cleared so the head reads 0 out of reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr[IW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + (IW+1)'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + (IW+1)'(1);
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Word-addressed RAM + MMIO (console TX FIFO, STATUS, CYCLES) behind the core port.
// Latency: reads return on mem_rdata one edge after the strobe; writes land on the strobe edge.
// Backpressure: none on the core port; TX bytes pushed into a full FIFO are dropped and flag ovf.
// Ports: clk, reset (async active-low), bus (mem_ctrl_if.slave: core port and TX stream).
module mem_ctrl
  import mem_map_pkg::*;
#(
  parameter int          ADDR_WIDTH   = 32,
  parameter int          RAM_DEPTH    = 1024,
  parameter int          FIFO_DEPTH   = 4,
  parameter string       INIT_FILE    = "",
  // Counter value loaded at reset; normally 0, nonzero only to reach the wrap quickly.
  parameter logic [31:0] CYCLES_RESET = 32'h0
) (
  input logic       clk,
  input logic       reset,
  mem_ctrl_if.slave bus
);

  localparam int RAM_AW = $clog2(RAM_DEPTH);

  logic [31:0]       ram [RAM_DEPTH];
  logic [RAM_AW-1:0] ram_idx;
  sel_e              sel;
  logic              do_rd;
  logic              do_wr;
  logic [31:0]       rd_word;
  logic [31:0]       status;
  logic [31:0]       cycles;
  logic              ovf;
  logic              bad;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;

  // RAM only decodes when every address bit above the index is zero.
  always_comb begin
    sel = SEL_BAD;
    if (bus.mem_addr[ADDR_WIDTH-1:RAM_AW] == '0)                sel = SEL_RAM;
    else if (bus.mem_addr == ADDR_WIDTH'(TXDATA_ADDR))          sel = SEL_TXDATA;
    else if (bus.mem_addr == ADDR_WIDTH'(STATUS_ADDR))          sel = SEL_STATUS;
    else if (bus.mem_addr == ADDR_WIDTH'(CYCLES_ADDR))          sel = SEL_CYCLES;
  end

  assign ram_idx = bus.mem_addr[RAM_AW-1:0];

  // A write strobe wins over a read strobe in the same cycle.
  assign do_wr = bus.mem_wr;
  assign do_rd = bus.mem_rd && !bus.mem_wr;

  assign fifo_push = do_wr && (sel == SEL_TXDATA);
  assign fifo_pop  = bus.tx_ready && !fifo_empty;

  assign status = pack_status(fifo_empty, fifo_full, ovf, bad);

  always_comb begin
    rd_word = '0;
    case (sel)
      SEL_RAM:    rd_word = ram[ram_idx];
      SEL_STATUS: rd_word = status;
      SEL_CYCLES: rd_word = cycles;
      default:    rd_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_wr && (sel == SEL_RAM)) ram[ram_idx] <= bus.mem_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.mem_rdata <= '0;
      cycles        <= CYCLES_RESET;
      ovf           <= 1'b0;
      bad           <= 1'b0;
    end else begin
      cycles <= cycles + 32'd1;
      if (do_rd) bus.mem_rdata <= rd_word;
      // A pop on the same edge makes room, so only an unrelieved full push overflows.
      if (fifo_push && fifo_full && !fifo_pop)
        ovf <= 1'b0 | 1'b1;
      else if (do_wr && (sel == SEL_STATUS) && bus.mem_wdata[ST_OVF])
        ovf <= 1'b0;
      if ((bus.mem_rd || bus.mem_wr) && (sel == SEL_BAD)) bad <= 1'b1;
    end
  end

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (bus.mem_wdata[7:0]),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (bus.tx_data)
  );

  assign bus.tx_valid = !fifo_empty;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed vector table, counter-wrap and reset sequences,
// then randomized traffic checked against a queue/array model of the address map.
module tb_mem_ctrl;

  localparam logic [31:0] A_TX  = 32'h4000_0000;
  localparam logic [31:0] A_ST  = 32'h4000_0001;
  localparam logic [31:0] A_CY  = 32'h4000_0002;
  localparam int          DEPTH = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_ctrl_if #(.ADDR_WIDTH(32)) bus ();
  mem_ctrl_if #(.ADDR_WIDTH(32)) bus2 ();

  mem_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  mem_ctrl #(.CYCLES_RESET(32'hFFFF_FFFC)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_ram [1024];
  logic [7:0]  m_q [$];
  logic        m_ovf;
  logic        m_bad;
  logic [31:0] m_cyc;
  logic [31:0] m_rdata;

  function automatic void m_reset();
    m_q.delete();
    m_ovf   = 1'b0;
    m_bad   = 1'b0;
    m_cyc   = 32'd0;
    m_rdata = 32'd0;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a < 32'd1024) return m_ram[a[9:0]];
    if (a == A_ST) return {28'd0, m_bad, m_ovf, m_q.size() == DEPTH, m_q.size() == 0};
    if (a == A_CY) return m_cyc;
    return 32'd0;
  endfunction

  // One clock edge of the address map, using the state as it was before the edge.
  function automatic void m_step(input logic rd, input logic wr, input logic [31:0] a,
                                 input logic [31:0] d, input logic rdy);
    logic popping;
    logic mapped;
    popping = (m_q.size() > 0) && rdy;
    mapped  = (a < 32'd1024) || (a == A_TX) || (a == A_ST) || (a == A_CY);
    if (rd && !wr) m_rdata = m_read(a);
    if ((rd || wr) && !mapped) m_bad = 1'b1;
    if (wr) begin
      if (a < 32'd1024) m_ram[a[9:0]] = d;
      else if (a == A_TX) begin
        if (m_q.size() < DEPTH || popping) m_q.push_back(d[7:0]);
        else m_ovf = 1'b1;
      end else if (a == A_ST && d[2]) m_ovf = 1'b0;
    end
    if (popping) void'(m_q.pop_front());
    m_cyc = m_cyc + 32'd1;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic rdy);
    bus.mem_rd    = rd;
    bus.mem_wr    = wr;
    bus.mem_addr  = a;
    bus.mem_wdata = d;
    bus.tx_ready  = rdy;
  endtask

  task automatic drive2(input logic rd, input logic [31:0] a);
    bus2.mem_rd   = rd;
    bus2.mem_addr = a;
  endtask

  task automatic tick();
    m_step(bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.tx_ready);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rdy;
    logic [31:0] exp_rdata;
    logic        exp_vld;
    logic [7:0]  exp_txd;
  } vec_t;

  vec_t tv[$];

  function automatic void add(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] d, input logic rdy,
                              input logic [31:0] er, input logic ev, input logic [7:0] et);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.wdata = d; v.rdy = rdy;
    v.exp_rdata = er; v.exp_vld = ev; v.exp_txd = et;
    tv.push_back(v);
  endfunction

  initial begin
    logic [31:0] ra;
    logic [31:0] rw;
    logic [31:0] k;

    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    bus2.mem_wr    = 1'b0;
    bus2.mem_wdata = 32'd0;
    bus2.tx_ready  = 1'b0;
    drive2(1'b0, 32'd0);

    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset rdata", bus.mem_rdata, 32'd0);
    chk("reset tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    chk("reset tx_data", {24'd0, bus.tx_data}, 32'd0);
    chk("reset rdata2", bus2.mem_rdata, 32'd0);
    reset = 1'b1;
    m_reset();

    // CYCLES from reset on the main instance, wrap on the preloaded one.
    drive(1'b1, 1'b0, A_CY, 32'd0, 1'b0);
    tick(); chk("cycles first", bus.mem_rdata, 32'd0);
    tick(); chk("cycles second", bus.mem_rdata, 32'd1);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    drive2(1'b1, A_CY);
    tick(); chk("wrap pre", bus2.mem_rdata, 32'hFFFF_FFFE);
    drive2(1'b0, A_CY);
    tick(); chk("wrap hold", bus2.mem_rdata, 32'hFFFF_FFFE);
    drive2(1'b1, A_CY);
    tick(); chk("wrap zero", bus2.mem_rdata, 32'd0);
    drive2(1'b0, 32'd0);

    // rd, wr, addr, wdata, rdy, exp_rdata, exp_vld, exp_txd
    add(0, 1, 32'd0, 32'hA5A5_A5A5, 0, 32'd1, 0, 8'h00);
    add(0, 1, 32'd5, 32'hDEAD_BEEF, 0, 32'd1, 0, 8'h00);
    add(1, 0, 32'd5, 32'd0,         0, 32'hDEAD_BEEF, 0, 8'h00);
    add(0, 0, 32'd0, 32'd0,         0, 32'hDEAD_BEEF, 0, 8'h00);
    add(0, 0, 32'd0, 32'd0,         0, 32'hDEAD_BEEF, 0, 8'h00);
    add(0, 0, 32'd0, 32'd0,         0, 32'hDEAD_BEEF, 0, 8'h00);
    add(0, 1, A_TX,  32'h41,        0, 32'hDEAD_BEEF, 1, 8'h41);
    add(0, 1, A_TX,  32'h42,        0, 32'hDEAD_BEEF, 1, 8'h41);
    add(0, 1, A_TX,  32'h43,        0, 32'hDEAD_BEEF, 1, 8'h41);
    add(0, 1, A_TX,  32'h44,        0, 32'hDEAD_BEEF, 1, 8'h41);
    add(0, 1, A_TX,  32'h45,        0, 32'hDEAD_BEEF, 1, 8'h41);
    add(1, 0, A_ST,  32'd0,         0, 32'h6, 1, 8'h41);
    add(0, 0, 32'd0, 32'd0,         1, 32'h6, 1, 8'h42);
    add(0, 0, 32'd0, 32'd0,         1, 32'h6, 1, 8'h43);
    add(0, 0, 32'd0, 32'd0,         1, 32'h6, 1, 8'h44);
    add(0, 0, 32'd0, 32'd0,         1, 32'h6, 0, 8'h00);
    add(1, 0, A_ST,  32'd0,         1, 32'h5, 0, 8'h00);
    add(0, 1, A_ST,  32'h4,         0, 32'h5, 0, 8'h00);
    add(1, 0, A_ST,  32'd0,         0, 32'h1, 0, 8'h00);
    add(0, 1, A_TX,  32'h11,        0, 32'h1, 1, 8'h11);
    add(0, 1, A_TX,  32'h22,        0, 32'h1, 1, 8'h11);
    add(0, 1, A_TX,  32'h33,        0, 32'h1, 1, 8'h11);
    add(0, 1, A_TX,  32'h44,        0, 32'h1, 1, 8'h11);
    add(0, 1, A_TX,  32'h55,        1, 32'h1, 1, 8'h22);
    add(1, 0, A_ST,  32'd0,         0, 32'h2, 1, 8'h22);
    add(0, 0, 32'd0, 32'd0,         1, 32'h2, 1, 8'h33);
    add(0, 0, 32'd0, 32'd0,         1, 32'h2, 1, 8'h44);
    add(0, 0, 32'd0, 32'd0,         1, 32'h2, 1, 8'h55);
    add(0, 0, 32'd0, 32'd0,         1, 32'h2, 0, 8'h00);
    add(0, 1, A_TX,  32'h66,        1, 32'h2, 1, 8'h66);
    add(0, 0, 32'd0, 32'd0,         1, 32'h2, 0, 8'h00);
    add(1, 0, A_ST,  32'd0,         0, 32'h1, 0, 8'h00);
    add(0, 1, 32'h2000_0000, 32'h1234_5678, 0, 32'h1, 0, 8'h00);
    add(1, 0, 32'h2000_0000, 32'd0, 0, 32'h0, 0, 8'h00);
    add(1, 0, A_ST,  32'd0,         0, 32'h9, 0, 8'h00);
    add(1, 0, 32'd0, 32'd0,         0, 32'hA5A5_A5A5, 0, 8'h00);
    add(1, 1, 32'd7, 32'hCAFE_F00D, 0, 32'hA5A5_A5A5, 0, 8'h00);
    add(1, 0, 32'd7, 32'd0,         0, 32'hCAFE_F00D, 0, 8'h00);
    add(1, 0, A_TX,  32'd0,         0, 32'h0, 0, 8'h00);
    add(1, 0, 32'h400, 32'd0,       0, 32'h0, 0, 8'h00);

    // The first two table rows only write, so mem_rdata still holds the last CYCLES read (1).
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].rd, tv[i].wr, tv[i].addr, tv[i].wdata, tv[i].rdy);
      tick();
      chk($sformatf("vec%0d rdata", i), bus.mem_rdata, tv[i].exp_rdata);
      chk($sformatf("vec%0d tx_valid", i), {31'd0, bus.tx_valid}, {31'd0, tv[i].exp_vld});
      if (tv[i].exp_vld)
        chk($sformatf("vec%0d tx_data", i), {24'd0, bus.tx_data}, {24'd0, tv[i].exp_txd});
    end

    // Reset with two bytes queued.
    drive(1'b0, 1'b1, A_TX, 32'h77, 1'b0); tick();
    drive(1'b0, 1'b1, A_TX, 32'h78, 1'b0); tick();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    chk("pre-reset tx_valid", {31'd0, bus.tx_valid}, 32'd1);
    reset = 1'b0;
    m_reset();
    #1;
    chk("midreset tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    chk("midreset rdata", bus.mem_rdata, 32'd0);
    chk("midreset tx_data", {24'd0, bus.tx_data}, 32'd0);
    #1 reset = 1'b1;
    drive(1'b1, 1'b0, A_CY, 32'd0, 1'b0); tick();
    chk("post-reset cycles", bus.mem_rdata, 32'd0);
    drive(1'b1, 1'b0, A_ST, 32'd0, 1'b0); tick();
    chk("post-reset status", bus.mem_rdata, 32'h1);
    drive(1'b1, 1'b0, 32'd5, 32'd0, 1'b0); tick();
    chk("post-reset ram5", bus.mem_rdata, 32'hDEAD_BEEF);

    // Randomized traffic against the model.
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, i, $urandom, 1'b0);
      tick();
    end
    for (int n = 0; n < 800; n++) begin
      k  = $urandom_range(0, 9);
      rw = $urandom_range(0, 3);
      case (k)
        0, 1, 2, 3: ra = $urandom_range(0, 15);
        4, 5:       ra = A_TX;
        6:          ra = A_ST;
        7:          ra = A_CY;
        8:          ra = 32'h4000_0003;
        default:    ra = 32'h0000_0400;
      endcase
      drive(rw[0], rw[1], ra, $urandom, ($urandom_range(0, 2) == 0));
      tick();
      chk($sformatf("rand%0d rdata", n), bus.mem_rdata, m_rdata);
      chk($sformatf("rand%0d tx_valid", n), {31'd0, bus.tx_valid},
          {31'd0, (m_q.size() != 0)});
      if (m_q.size() != 0)
        chk($sformatf("rand%0d tx_data", n), {24'd0, bus.tx_data}, {24'd0, m_q[0]});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
